// File: rtl/muldiv_hilo.sv
// muldiv_hilo: multi-cycle multiply/divide unit with HI/LO registers for the
// EX stage. Operands arrive already forwarded; results land in HI/LO after a
// fixed latency and stay hidden until then.
//
// Ports:
//   clk, reset     clock and synchronous active-high reset
//   start, op      launch mult(00) / multu(01) / div(10) / divu(11)
//   A, B           forwarded RS / RT operands
//   mthi, mtlo     write A into HI / LO (only while idle and not starting)
//   busy           registered, high while an operation is in flight
//   HI, LO         registered HI/LO registers (mfhi/mflo source)
module muldiv_hilo #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        mthi,
  input  logic        mtlo,
  output logic        busy,
  output logic [31:0] HI,
  output logic [31:0] LO
);

  localparam int unsigned DW    = 32;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        op_q, op_d;
  logic [DW-1:0]     a_q, a_d;
  logic [DW-1:0]     b_q, b_d;
  logic [DW-1:0]     hi_q, hi_d;
  logic [DW-1:0]     lo_q, lo_d;
  logic              busy_q, busy_d;

  // Combinational result core on the latched operands; only sampled at the
  // final RUN edge, so its intermediate settling is never visible.
  logic [2*DW-1:0]      prod_s_c, prod_u_c;
  logic signed [DW-1:0] sa_c, sb_c, quo_s_c, rem_s_c;
  logic [DW-1:0]        quo_u_c, rem_u_c;
  logic [DW-1:0]        res_hi_c, res_lo_c;
  logic                 res_wr_c;

  always_comb begin
    sa_c     = a_q;
    sb_c     = b_q;
    // Sign-extended operands: the low 64 bits of the product are the signed result.
    prod_s_c = {{DW{a_q[DW-1]}}, a_q} * {{DW{b_q[DW-1]}}, b_q};
    prod_u_c = {{DW{1'b0}}, a_q} * {{DW{1'b0}}, b_q};
    quo_s_c  = '0;
    rem_s_c  = '0;
    quo_u_c  = '0;
    rem_u_c  = '0;
    if (b_q != '0) begin
      quo_s_c = sa_c / sb_c;
      rem_s_c = sa_c % sb_c;
      quo_u_c = a_q / b_q;
      rem_u_c = a_q % b_q;
    end
    res_hi_c = hi_q;
    res_lo_c = lo_q;
    res_wr_c = 1'b1;
    unique case (op_q)
      2'b00: begin
        res_hi_c = prod_s_c[2*DW-1:DW];
        res_lo_c = prod_s_c[DW-1:0];
      end
      2'b01: begin
        res_hi_c = prod_u_c[2*DW-1:DW];
        res_lo_c = prod_u_c[DW-1:0];
      end
      2'b10: begin
        if (b_q == '0) begin
          res_wr_c = 1'b0;
        end else if (a_q == 32'h8000_0000 && b_q == 32'hFFFF_FFFF) begin
          // Signed overflow: quotient wraps to the dividend, remainder zero.
          res_lo_c = 32'h8000_0000;
          res_hi_c = '0;
        end else begin
          res_lo_c = DW'(quo_s_c);
          res_hi_c = DW'(rem_s_c);
        end
      end
      default: begin
        if (b_q == '0) begin
          res_wr_c = 1'b0;
        end else begin
          res_lo_c = quo_u_c;
          res_hi_c = rem_u_c;
        end
      end
    endcase
  end

  // Next-state logic: launch, count down, write back, and mthi/mtlo.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          op_d    = op;
          a_d     = A;
          b_d     = B;
          cnt_d   = op[1] ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
          state_d = RUN;
          busy_d  = 1'b1;
        end else begin
          if (mthi) hi_d = A;
          if (mtlo) lo_d = A;
        end
      end
      RUN: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) begin
          cnt_d   = '0;
          state_d = IDLE;
          busy_d  = 1'b0;
          if (res_wr_c) begin
            hi_d = res_hi_c;
            lo_d = res_lo_c;
          end
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

// File: doc/muldiv_hilo.md
# muldiv_hilo

Multiply/divide unit with HI/LO registers for the EX stage of the five-stage MIPS pipeline. Consumes the already-forwarded RS/RT operands of the E stage: bypass selection is complete before this block, so no forwarding logic lives here. Executes `mult`, `multu`, `div` and `divu` over a fixed multi-cycle latency and handles `mthi`/`mtlo`. Exports `busy` to the stall controller, and exports HI/LO as the source for `mfhi`/`mflo`. That `mfhi`/`mflo` value becomes the HILO_M forwarding source downstream.

## Interface
- `MULT_CYCLES`, 5: busy cycles for `mult`/`multu`.
- `DIV_CYCLES`, 10: busy cycles for `div`/`divu`.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `start`  in  1  E stage holds a valid mult/multu/div/divu this cycle and is not stalled.
- `op`  in  2  operation select: 00 `mult`, 01 `multu`, 10 `div`, 11 `divu`; sampled with `start`.
- `A`  in  32  forwarded RS operand of the E stage.
- `B`  in  32  forwarded RT operand of the E stage.
- `mthi`  in  1  write `A` into HI.
- `mtlo`  in  1  write `A` into LO.
- `busy`  out  1  an operation is in flight.
- `HI`  out  32  HI register, registered output.
- `LO`  out  32  LO register, registered output.

## Operation
- States: IDLE, RUN. A down-counter (4 bits minimum) holds the remaining cycles.
- **IDLE, `start`=1:**
  - Latch `op`, `A`, `B`.
  - Load the counter with `MULT_CYCLES` or `DIV_CYCLES`.
  - Go to RUN.
- **RUN:**
  - Decrement the counter each cycle.
  - When the counter reaches 1, write the result to HI/LO at that edge and return to IDLE.
- **Multiply results:**
  - `mult`: {HI,LO} = signed 64-bit product of A×B.
  - `multu`: {HI,LO} = unsigned 64-bit product of A×B.
- **Divide results:**
  - `div`: LO = quotient truncated toward zero; HI = remainder, which takes the sign of the dividend (A).
  - `divu`: unsigned quotient and remainder.
- **Divide boundary cases:**
  - Divisor B = 0: HI/LO unchanged, and `busy` still runs the full `DIV_CYCLES`.
  - `div` with A=0x80000000, B=0xFFFFFFFF: LO=0x80000000, HI=0.
- **HI/LO during RUN:** hold their old values throughout. Intermediate results are never visible.
- **`mthi`/`mtlo`:**
  - Take effect only in IDLE with `start`=0: HI or LO ← A at the next edge.
  - Ignored when `busy`=1 or `start`=1.
  - `mthi`=`mtlo`=1 together writes both registers.
- **`start` while `busy`=1:** ignored; the in-flight operation completes unaffected. The stall controller guarantees this never occurs legally.
- **Internal implementation:** free (iterative shift-add / restoring divide, or combinational core plus delay counter), provided externally visible timing matches this document.
- **Reset:** `busy`=0, HI=0, LO=0, state IDLE, counter 0. A reset mid-operation discards the in-flight result.

## Timing
- `start`=1 in cycle 0. `busy`=1 in cycles 1..N, where N=`MULT_CYCLES` or `DIV_CYCLES`.
- In cycle N+1: `busy`=0 and HI/LO show the new result.
- A new `start` is accepted in cycle N+1, so back-to-back operations have 1 idle cycle.
- **Stall contract:** the stall controller stalls D on (`start` | `busy`) whenever D holds mult/div/mfhi/mflo/mthi/mtlo. Consequently `mfhi` reaching M always reads a settled HI.
- `mthi`/`mtlo` in cycle k: the new HI/LO value is visible in cycle k+1.
- `busy` is a pure register output with no combinational path from `start`. The stall controller is responsible for OR-ing in `start`.
- Reset asserted in any cycle: all outputs are at reset values in the next cycle, and the block is IDLE.

## Test plan
- **Signed multiply:** reset, then `start`, `op`=00, A=0xFFFFFFFE (-2), B=3.
  - `busy` high in cycles 1–5.
  - Cycle 6: HI=0xFFFFFFFF, LO=0xFFFFFFFA.
- **Unsigned multiply:** `op`=01, A=0xFFFFFFFF, B=2 → after 5 cycles HI=0x00000001, LO=0xFFFFFFFE.
- **Signed divide:** `op`=10, A=-7 (0xFFFFFFF9), B=2.
  - `busy` high in cycles 1–10.
  - Cycle 11: LO=0xFFFFFFFD (-3), HI=0xFFFFFFFF (-1).
  - Repeat with A=0x80000000, B=0xFFFFFFFF → LO=0x80000000, HI=0.
- **Divide by zero:** preload HI=0x11, LO=0x22 via `mthi`/`mtlo`, then `op`=11, A=5, B=0.
  - `busy` high for 10 cycles.
  - HI=0x11, LO=0x22 afterward.
- **Ignored writes while busy:** start `mult` 3×4.
  - Pulse `mthi` with A=0xDEAD and `start` with new operands during cycle 3.
  - Both are ignored. Cycle 6: HI=0, LO=12, then `mthi` A=0xBEEF in cycle 6 → HI=0xBEEF in cycle 7.
- **Reset mid-operation:** start `divu` 100/7, assert `reset` in cycle 4.
  - Cycle 5: `busy`=0, HI=0, LO=0.
  - No later writeback occurs.
  - A fresh `divu` 100/7 gives LO=14, HI=2 after 10 cycles.
